// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the generator and checker ends of the packet
// datapath: constants, checker state encoding and the byte-update function.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    TRAILER = 2'd1,
    DROP    = 2'd2,
    REPORT  = 2'd3
  } crc_chk_state_t;

  // Reflected CRC-32, one byte per call, bits consumed LSB-first.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_check.sv
// Receive-side CRC-32 checker: one fixed-length payload followed by a 4-byte
// little-endian trailer; reports pass, fail or framing error per packet.
module crc_check
  import crc_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_crc_ok,
  output logic        out_frame_err,
  output logic [31:0] out_crc,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_BYTES - 1);

  crc_chk_state_t state_r, state_s;
  logic [31:0]    crc_r, crc_s, rx_crc_r, rx_crc_s, crc_upd_s, out_crc_s;
  logic [15:0]    byte_cnt_r, byte_cnt_s, err_cnt_s;
  logic [1:0]     trl_cnt_r, trl_cnt_s;
  logic           accept_s, ok_s, ferr_s;

  assign in_ready  = (state_r != REPORT);
  assign accept_s  = in_valid && in_ready;
  assign crc_upd_s = crc32_byte_update(crc_r, in_data);

  // Next-state, datapath and result decode for the packet framing FSM.
  always_comb begin
    state_s    = state_r;
    crc_s      = crc_r;
    rx_crc_s   = rx_crc_r;
    byte_cnt_s = byte_cnt_r;
    trl_cnt_s  = trl_cnt_r;
    ok_s       = out_crc_ok;
    ferr_s     = out_frame_err;
    out_crc_s  = out_crc;
    err_cnt_s  = err_cnt;
    case (state_r)
      PAYLOAD: begin
        if (accept_s) begin
          crc_s      = crc_upd_s;
          byte_cnt_s = byte_cnt_r + 16'd1;
          if (in_last) begin
            state_s   = REPORT;
            ok_s      = 1'b0;
            ferr_s    = 1'b1;
            out_crc_s = crc_upd_s ^ CRC32_XOROUT;
          end else if (byte_cnt_r == LAST_IDX) begin
            state_s = TRAILER;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      TRAILER: begin
        if (accept_s) begin
          rx_crc_s[{trl_cnt_r, 3'b000} +: 8] = in_data;
          trl_cnt_s = trl_cnt_r + 2'd1;
          if (trl_cnt_r == 2'd3) begin
            if (in_last) begin
              state_s   = REPORT;
              ferr_s    = 1'b0;
              ok_s      = ((crc_r ^ CRC32_XOROUT) == rx_crc_s);
              out_crc_s = crc_r ^ CRC32_XOROUT;
            end else begin
              state_s = DROP;
            end
          end else if (in_last) begin
            state_s   = REPORT;
            ok_s      = 1'b0;
            ferr_s    = 1'b1;
            out_crc_s = crc_r ^ CRC32_XOROUT;
          end else begin
            state_s = TRAILER;
          end
        end else begin
          state_s = TRAILER;
        end
      end
      DROP: begin
        if (accept_s && in_last) begin
          state_s   = REPORT;
          ok_s      = 1'b0;
          ferr_s    = 1'b1;
          out_crc_s = crc_r ^ CRC32_XOROUT;
        end else begin
          state_s = DROP;
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_s    = PAYLOAD;
          crc_s      = CRC32_INIT;
          rx_crc_s   = 32'h0000_0000;
          byte_cnt_s = 16'd0;
          trl_cnt_s  = 2'd0;
          if (!out_crc_ok && (err_cnt != 16'hFFFF)) begin
            err_cnt_s = err_cnt + 16'd1;
          end else begin
            err_cnt_s = err_cnt;
          end
        end else begin
          state_s = REPORT;
        end
      end
      default: begin
        state_s    = PAYLOAD;
        crc_s      = CRC32_INIT;
        rx_crc_s   = 32'h0000_0000;
        byte_cnt_s = 16'd0;
        trl_cnt_s  = 2'd0;
      end
    endcase
  end

  // State, datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= PAYLOAD;
      crc_r         <= CRC32_INIT;
      rx_crc_r      <= 32'h0000_0000;
      byte_cnt_r    <= 16'd0;
      trl_cnt_r     <= 2'd0;
      out_valid     <= 1'b0;
      out_crc_ok    <= 1'b0;
      out_frame_err <= 1'b0;
      out_crc       <= 32'h0000_0000;
      err_cnt       <= 16'd0;
    end else begin
      state_r       <= state_s;
      crc_r         <= crc_s;
      rx_crc_r      <= rx_crc_s;
      byte_cnt_r    <= byte_cnt_s;
      trl_cnt_r     <= trl_cnt_s;
      out_valid     <= (state_s == REPORT);
      out_crc_ok    <= ok_s;
      out_frame_err <= ferr_s;
      out_crc       <= out_crc_s;
      err_cnt       <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Bench for crc_check: a 9-byte and a 40-byte instance share stimulus; a
// table-driven CRC-32 model predicts each packet's outcome from its framing.
`timescale 1ns/1ps
module tb_crc_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        iv9, or9, rdy9, ov9, ok9, fe9;
  logic        iv40, or40, rdy40, ov40, ok40, fe40;
  logic [31:0] crc9, crc40;
  logic [15:0] ec9, ec40;
  logic        o_rdy, o_valid, o_ok, o_fe;
  logic [31:0] o_crc;
  logic [15:0] o_ec;

  int          total = 0;
  int          bad = 0;
  int          err_m[2];
  logic [31:0] tbl[256];
  logic [7:0]  pkt[$];

  always #5 clk = ~clk;

  assign iv9  = in_valid & ~sel;
  assign or9  = out_ready & ~sel;
  assign iv40 = in_valid & sel;
  assign or40 = out_ready & sel;

  assign o_rdy   = sel ? rdy40 : rdy9;
  assign o_valid = sel ? ov40  : ov9;
  assign o_ok    = sel ? ok40  : ok9;
  assign o_fe    = sel ? fe40  : fe9;
  assign o_crc   = sel ? crc40 : crc9;
  assign o_ec    = sel ? ec40  : ec9;

  crc_check #(.PAYLOAD_BYTES(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(rdy9), .in_data(in_data),
    .in_last(in_last), .out_valid(ov9), .out_ready(or9), .out_crc_ok(ok9),
    .out_frame_err(fe9), .out_crc(crc9), .err_cnt(ec9)
  );

  crc_check #(.PAYLOAD_BYTES(40)) dut40 (
    .clk(clk), .rst(rst), .in_valid(iv40), .in_ready(rdy40), .in_data(in_data),
    .in_last(in_last), .out_valid(ov40), .out_ready(or40), .out_crc_ok(ok40),
    .out_frame_err(fe40), .out_crc(crc40), .err_cnt(ec40)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_table();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[n] = c;
    end
  endtask

  // Standard table-driven CRC-32 over the first n bytes of pkt.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = (c >> 8) ^ tbl[c[7:0] ^ pkt[i]];
    return ~c;
  endfunction

  task automatic build_good(input int p);
    logic [31:0] c;
    pkt.delete();
    for (int i = 0; i < p; i++) pkt.push_back(8'($urandom_range(255)));
    c = ref_crc(p);
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
    pkt.push_back(c[23:16]);
    pkt.push_back(c[31:24]);
  endtask

  // Send pkt (in_last on its final byte), hold the result, then accept it.
  task automatic send_packet(input int gap, input int hold, input string nm);
    int p, len, tries, idx;
    logic [31:0] e_crc, rx;
    logic e_ok, e_fe, rdy;
    p = sel ? 40 : 9;
    idx = sel ? 1 : 0;
    len = pkt.size();
    e_ok = 1'b0;
    if (len <= p) begin
      e_fe = 1'b1;
      e_crc = ref_crc(len);
    end else begin
      e_crc = ref_crc(p);
      if (len == p + 4) begin
        e_fe = 1'b0;
        rx = {pkt[p+3], pkt[p+2], pkt[p+1], pkt[p]};
        e_ok = (rx == e_crc);
      end else begin
        e_fe = 1'b1;
      end
    end
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data = pkt[i];
      in_last = (i == len - 1);
      tries = 0;
      do begin
        rdy = o_rdy;
        step();
        tries++;
      end while (!rdy && tries < 50);
      if (!rdy) begin
        total++; bad++;
        $display("FAIL %s in_ready timeout at byte %0d got=%0b want=1", nm, i, rdy);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    total++;
    if (o_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s latency out_valid got=%0b want=1", nm, o_valid);
    end
    for (int h = 0; h < hold; h++) begin
      total++;
      if (o_valid !== 1'b1 || o_rdy !== 1'b0 || o_ok !== e_ok || o_fe !== e_fe || o_crc !== e_crc) begin
        bad++;
        $display("FAIL %s hold%0d got v=%0b rdy=%0b ok=%0b fe=%0b crc=%h want v=1 rdy=0 ok=%0b fe=%0b crc=%h",
                 nm, h, o_valid, o_rdy, o_ok, o_fe, o_crc, e_ok, e_fe, e_crc);
      end
      step();
    end
    total++;
    if (o_ok !== e_ok) begin bad++; $display("FAIL %s crc_ok got=%0b want=%0b", nm, o_ok, e_ok); end
    total++;
    if (o_fe !== e_fe) begin bad++; $display("FAIL %s frame_err got=%0b want=%0b", nm, o_fe, e_fe); end
    total++;
    if (o_crc !== e_crc) begin bad++; $display("FAIL %s out_crc got=%h want=%h", nm, o_crc, e_crc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (!e_ok && err_m[idx] != 65535) err_m[idx]++;
    total++;
    if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin
      bad++;
      $display("FAIL %s after_accept got v=%0b rdy=%0b want v=0 rdy=1", nm, o_valid, o_rdy);
    end
    total++;
    if (o_ec !== 16'(err_m[idx])) begin
      bad++;
      $display("FAIL %s err_cnt got=%0d want=%0d", nm, o_ec, err_m[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    err_m[0] = 0;
    err_m[1] = 0;
    total++;
    if ({ov9, ok9, fe9, crc9, ec9, rdy9} !== {3'b000, 32'h0, 16'h0, 1'b1} ||
        {ov40, ok40, fe40, crc40, ec40, rdy40} !== {3'b000, 32'h0, 16'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset got v=%0b/%0b ok=%0b/%0b fe=%0b/%0b crc=%h/%h ec=%0d/%0d rdy=%0b/%0b want zeros rdy=1",
               ov9, ov40, ok9, ok40, fe9, fe40, crc9, crc40, ec9, ec40, rdy9, rdy40);
    end
  endtask

  task automatic load_check_string(input logic [7:0] t0);
    string s;
    s = "123456789";
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(s[i]);
    pkt.push_back(t0);
    pkt.push_back(8'h39);
    pkt.push_back(8'hF4);
    pkt.push_back(8'hCB);
  endtask

  task automatic test_check_value();
    sel = 1'b0;
    load_check_string(8'h26);
    send_packet(0, 0, "check_good");
    total++;
    if (o_crc !== 32'hCBF43926) begin bad++; $display("FAIL check_const got=%h want=cbf43926", o_crc); end
    load_check_string(8'h27);
    send_packet(0, 0, "check_bad");
  endtask

  task automatic test_random_gaps();
    sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      build_good(40);
      send_packet(30, 5, "gaps");
    end
  endtask

  task automatic test_framing();
    sel = 1'b1;
    pkt.delete();
    for (int i = 0; i < 21; i++) pkt.push_back(8'($urandom_range(255)));
    send_packet(0, 1, "early_last");
    build_good(40);
    send_packet(0, 0, "after_early");
    build_good(40);
    pkt.push_back(8'($urandom_range(255)));
    pkt.push_back(8'($urandom_range(255)));
    send_packet(0, 1, "drop");
    build_good(40);
    void'(pkt.pop_back());
    void'(pkt.pop_back());
    send_packet(0, 1, "short_trailer");
  endtask

  task automatic test_random_mix();
    int p, len;
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(1));
      p = sel ? 40 : 9;
      build_good(p);
      case ($urandom_range(2))
        0: pkt[$urandom_range(p + 3)] ^= 8'(1 << $urandom_range(7));
        1: begin
          len = $urandom_range(1, p + 6);
          while (pkt.size() > len) void'(pkt.pop_back());
          while (pkt.size() < len) pkt.push_back(8'($urandom_range(255)));
        end
        default: ;
      endcase
      send_packet(20, 2, "mix");
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    build_good(40);
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data = pkt[i];
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    err_m[0] = 0;
    err_m[1] = 0;
    total++;
    if (ov40 !== 1'b0 || ec40 !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%0b ec=%0d want v=0 ec=0", ov40, ec40);
    end
    send_packet(0, 0, "reset_mid_good");
    step();
    total++;
    if (ov40 !== 1'b0) begin bad++; $display("FAIL reset_mid_extra got v=%0b want=0", ov40); end
  endtask

  task automatic bad_burst(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_last = 1'b1;
      in_data = 8'($urandom_range(255));
      step();
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_saturate();
    sel = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    bad_burst(65534);
    total++;
    if (ec9 !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", ec9); end
    bad_burst(2);
    total++;
    if (ec9 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", ec9); end
  endtask

  initial begin
    build_table();
    test_reset();
    test_check_value();
    test_random_gaps();
    test_framing();
    test_random_mix();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side CRC-32 checker for the packet parser datapath. Accepts a byte stream of one fixed-length payload followed by a 4-byte CRC trailer. Recomputes the CRC over the payload, compares it with the trailer, and reports pass, fail or framing error per packet. It is the verifying end of the CRC-32 generator used on the build side: same polynomial, same byte order, same bit order.

## Interface
- `PAYLOAD_BYTES`, default 40: payload length in bytes. Must be ≥1.
- `clk` input, 1: single clock; all logic is on the posedge.
- `rst` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `in_data` is valid this cycle.
- `in_ready` output, 1: checker can accept a byte.
- `in_data` input, 8: stream byte.
- `in_last` input, 1: marks the final byte of the packet.
- `out_valid` output, 1: result available; held until accepted.
- `out_ready` input, 1: downstream accepts the result.
- `out_crc_ok` output, 1: computed CRC equals the received CRC and framing is good.
- `out_frame_err` output, 1: `in_last` was early, late or missing.
- `out_crc` output, 32: final computed CRC (after final XOR).
- `err_cnt` output, 16: saturating count of packets reported with `out_crc_ok`=0.

## Operation
**CRC definition**
- Reflected CRC-32: poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
- Within a byte, bits are processed LSB-first.
- Payload byte 0 is the first byte accepted; it corresponds to the generator's most-significant input byte.

**Trailer format**
- 4 bytes, little-endian: first trailer byte is `rx_crc[7:0]`, last is `rx_crc[31:24]`.

**Acceptance**
- A byte is accepted when `in_valid && in_ready`.
- `in_ready` is decoded from state: 1 in PAYLOAD, TRAILER and DROP; 0 in REPORT.

**States**
- **PAYLOAD** (reset state):
  - Each accepted byte updates `crc_q` (all 8 bit steps in one cycle) and increments `byte_cnt`.
  - `in_last` on any payload byte → REPORT with `frame_err`=1.
  - Byte `PAYLOAD_BYTES-1` accepted without `in_last` → TRAILER.
- **TRAILER**:
  - Accepted byte k (0..3) is written into `rx_crc[8k+:8]`.
  - `in_last` with k<3 → REPORT with `frame_err`=1.
  - k=3 with `in_last` → REPORT; `crc_ok` = ((`crc_q` ^ 0xFFFFFFFF) == `rx_crc`).
  - k=3 without `in_last` → DROP.
- **DROP**:
  - Accept and discard bytes until one carries `in_last`, then → REPORT with `frame_err`=1.
- **REPORT**:
  - `out_valid`=1; `out_crc_ok`, `out_frame_err` and `out_crc` are stable.
  - On `out_ready`: `crc_q` ← 0xFFFFFFFF, counters ← 0, `rx_crc` ← 0, → PAYLOAD.
  - `err_cnt` increments by 1 (saturating at 0xFFFF) on that handshake when `out_crc_ok`=0.

**Rules and boundaries**
- `out_crc_ok`=1 only if `out_frame_err`=0.
- `out_crc` always reflects the payload bytes actually consumed.
- `in_valid` low stalls without changing state.
- Reset mid-packet: partial packet is discarded and no result is reported.
- `err_cnt` is cleared only by reset.

## Timing
- Reset values:
  - `out_valid`=0, `out_crc_ok`=0, `out_frame_err`=0, `out_crc`=0, `err_cnt`=0.
  - State is PAYLOAD, so `in_ready`=1 once `rst` deasserts.
- Throughput: one byte per cycle, with no bubbles inside a packet.
- Latency: `out_valid` rises the cycle after the terminating byte is accepted.
- On the `out_valid && out_ready` cycle N, `out_valid` is 0 and `in_ready` is 1 in cycle N+1.
- Minimum packet period: `PAYLOAD_BYTES` + 4 + 1 cycles.
- The input and output handshakes never overlap, because `in_ready`=0 throughout REPORT.

## Structure
- Shared package `crc_pkg` contains:
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_XOROUT` constants.
  - `crc_chk_state_t` enum: PAYLOAD, TRAILER, DROP, REPORT.
  - Function `crc32_byte_update(crc, byte)`: one byte, LSB-first, 8 unrolled steps.
- The generator should import the same package so both ends are guaranteed to match.
- Single module; no sub-module.
- Next-state logic in one `always_comb`; registers in one `always_ff` with async active-low reset.

## Test plan
- `PAYLOAD_BYTES`=9, payload ASCII "123456789", trailer 26 39 F4 CB with `in_last` on 0xCB → `out_valid` one cycle later, `out_crc`=0xCBF43926, `out_crc_ok`=1, `out_frame_err`=0, `err_cnt`=0.
- Same packet with trailer byte 0 changed to 0x27 → `out_crc_ok`=0, `out_crc`=0xCBF43926, `err_cnt`=1.
- Default 40-byte random payload plus model-generated trailer, with random `in_valid` gaps and `out_ready` held low 5 cycles → `out_crc_ok`=1; result held stable 5 cycles; `in_ready`=0 throughout.
- `in_last` on payload byte 20 → immediate REPORT, `out_frame_err`=1, `out_crc_ok`=0. Next good packet passes.
- No `in_last` on trailer byte 3; 2 extra bytes, `in_last` on the second → DROP consumes both, then `out_frame_err`=1.
- Reset pulsed at payload byte 15, then a full good packet → exactly one report, `out_crc_ok`=1. 65 536 bad packets → `err_cnt` saturates at 0xFFFF.
